// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types and default timing constants for the pong board logic
package pong_pkg;

  localparam int CLK25_HZ      = 25_000_000;
  localparam int DEBOUNCE_10MS = CLK25_HZ / 100;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } repeat_state_t;

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button pins in, conditioned button events out
interface button_conditioner_if #(
  parameter int NUM_BUTTONS = 3
);

  logic [NUM_BUTTONS-1:0] button_raw;
  logic                   frame_tick;
  logic [NUM_BUTTONS-1:0] button_level;
  logic [NUM_BUTTONS-1:0] button_press;
  logic [NUM_BUTTONS-1:0] button_release;
  logic [NUM_BUTTONS-1:0] button_repeat;
  logic [NUM_BUTTONS-1:0] button_step;

  modport master (
    output button_raw,
    output frame_tick,
    input  button_level,
    input  button_press,
    input  button_release,
    input  button_repeat,
    input  button_step
  );

  modport slave (
    input  button_raw,
    input  frame_tick,
    output button_level,
    output button_press,
    output button_release,
    output button_repeat,
    output button_step
  );

endinterface

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button: synchroniser, counter debounce, edge pulses, frame-locked repeat
module button_channel
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEBOUNCE_10MS,
  parameter int REPEAT_DELAY_FRAMES = 30,
  parameter int REPEAT_RATE_FRAMES  = 4
) (
  input  logic clk25,
  input  logic rst_n,
  input  logic button_raw_i,
  input  logic frame_tick_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES);
  localparam int FMAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ? REPEAT_DELAY_FRAMES
                                                                   : REPEAT_RATE_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          settle;
  logic          press_q, release_q, repeat_q;
  repeat_state_t state_q;
  logic [FW-1:0] fcnt_q;

  assign settle = (sync2_q != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

  // Any cycle where the synchronised pin agrees with the level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (settle) level_d = sync2_q;
      else        cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= button_raw_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= settle & sync2_q;
      release_q <= settle & ~sync2_q;
    end
  end

  // Keyed off the visible press pulse, so a tick in the press cycle is never counted.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fcnt_q   <= '0;
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press_q) begin
            state_q <= DELAY;
            fcnt_q  <= '0;
          end
        end
        DELAY: begin
          if (!level_q) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
          end else if (frame_tick_i) begin
            if (fcnt_q == FW'(REPEAT_DELAY_FRAMES - 1)) begin
              repeat_q <= 1'b1;
              state_q  <= REPEAT;
              fcnt_q   <= '0;
            end else begin
              fcnt_q <= fcnt_q + 1'b1;
            end
          end
        end
        REPEAT: begin
          if (!level_q) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
          end else if (frame_tick_i) begin
            if (fcnt_q == FW'(REPEAT_RATE_FRAMES - 1)) begin
              repeat_q <= 1'b1;
              fcnt_q   <= '0;
            end else begin
              fcnt_q <= fcnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          fcnt_q  <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-button conditioning channels plus the step (press | repeat) merge
module button_conditioner
  import pong_pkg::*;
#(
  parameter int NUM_BUTTONS         = 3,
  parameter int DEBOUNCE_CYCLES     = DEBOUNCE_10MS,
  parameter int REPEAT_DELAY_FRAMES = 30,
  parameter int REPEAT_RATE_FRAMES  = 4
) (
  input logic                 clk25,
  input logic                 rst_n,
  button_conditioner_if.slave bus
);

  logic [NUM_BUTTONS-1:0] level_w, press_w, release_w, repeat_w;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_FRAMES(REPEAT_DELAY_FRAMES),
      .REPEAT_RATE_FRAMES (REPEAT_RATE_FRAMES)
    ) u_ch (
      .clk25       (clk25),
      .rst_n       (rst_n),
      .button_raw_i(bus.button_raw[g]),
      .frame_tick_i(bus.frame_tick),
      .level_o     (level_w[g]),
      .press_o     (press_w[g]),
      .release_o   (release_w[g]),
      .repeat_o    (repeat_w[g])
    );
  end

  assign bus.button_level   = level_w;
  assign bus.button_press   = press_w;
  assign bus.button_release = release_w;
  assign bus.button_repeat  = repeat_w;
  assign bus.button_step    = press_w | repeat_w;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized bench for button_conditioner against a behavioural model
module tb_button_conditioner;

  localparam int NB   = 3;
  localparam int DEB  = 8;
  localparam int DLY  = 3;
  localparam int RATE = 2;
  localparam int TP   = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  button_conditioner_if #(.NUM_BUTTONS(NB)) bus ();

  button_conditioner #(
    .NUM_BUTTONS        (NB),
    .DEBOUNCE_CYCLES    (DEB),
    .REPEAT_DELAY_FRAMES(DLY),
    .REPEAT_RATE_FRAMES (RATE)
  ) dut (
    .clk25(clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Model: a level flips once the last DEB synchronised samples all disagree with it;
  // repeats fire when the count of ticks held since the press hits DLY, DLY+RATE, ...
  logic [NB-1:0]  e_level, e_press, e_rel, e_rep;
  logic [NB-1:0]  m1, m2;
  logic [DEB-1:0] win [NB];
  bit             armed [NB];
  int             nt [NB];

  task automatic model_reset();
    e_level = '0; e_press = '0; e_rel = '0; e_rep = '0;
    m1 = '0; m2 = '0;
    for (int c = 0; c < NB; c++) begin
      win[c] = '0; armed[c] = 1'b0; nt[c] = 0;
    end
  endtask

  task automatic model_step(input logic [NB-1:0] r, input logic t);
    logic seen, flip, rep_n;
    for (int c = 0; c < NB; c++) begin
      rep_n = 1'b0;
      if (e_press[c]) begin
        armed[c] = 1'b1;
        nt[c]    = 0;
      end else if (!e_level[c]) begin
        armed[c] = 1'b0;
      end else if (armed[c] && t) begin
        nt[c]++;
        if (nt[c] == DLY || (nt[c] > DLY && (nt[c] - DLY) % RATE == 0)) rep_n = 1'b1;
      end
      seen   = m2[c];
      m2[c]  = m1[c];
      m1[c]  = r[c];
      win[c] = {win[c][DEB-2:0], seen};
      flip   = e_level[c] ? (win[c] == '0) : (win[c] == '1);
      e_press[c] = flip & ~e_level[c];
      e_rel[c]   = flip & e_level[c];
      if (flip) e_level[c] = ~e_level[c];
      e_rep[c] = rep_n;
    end
  endtask

  task automatic compare();
    check("level",   bus.button_level,   e_level);
    check("press",   bus.button_press,   e_press);
    check("release", bus.button_release, e_rel);
    check("repeat",  bus.button_repeat,  e_rep);
    check("step",    bus.button_step,    e_press | e_rep);
  endtask

  task automatic cycle(input logic [NB-1:0] r, input logic t);
    @(negedge clk);
    bus.button_raw = r;
    bus.frame_tick = t;
    @(posedge clk);
    model_step(r, t);
    #1 compare();
    cyc++;
  endtask

  task automatic run(input logic [NB-1:0] r, input int n);
    for (int i = 0; i < n; i++) cycle(r, (cyc % TP) == 0);
  endtask

  task automatic press_latency(input string tag, input logic [NB-1:0] r);
    int lat = -1;
    for (int i = 0; i < 30; i++) begin
      cycle(r, (cyc % TP) == 0);
      if (bus.button_press[0] && lat < 0) lat = i + 1;
    end
    check(tag, lat, 2 + DEB);
  endtask

  task automatic random_phase(input int n, input bit rand_tick);
    int            dur [NB];
    logic [NB-1:0] rv;
    logic          t;
    rv = '0;
    for (int c = 0; c < NB; c++) dur[c] = $urandom_range(1, 60);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < NB; c++) begin
        if (dur[c] == 0) begin
          rv[c]  = ~rv[c];
          dur[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : $urandom_range(10, 220);
        end
        dur[c]--;
      end
      t = rand_tick ? ($urandom_range(0, 3) == 0) : ((cyc % TP) == 0);
      cycle(rv, t);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.button_raw = '0;
    bus.frame_tick = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 compare();
    #2 rst_n = 1'b1;

    press_latency("press_lat", 3'b001);
    run(3'b001, 170);
    run(3'b000, 40);
    run(3'b010, 7);
    run(3'b000, 40);
    run(3'b010, 9);
    run(3'b000, 60);
    run(3'b100, 50);
    run(3'b000, 10);
    run(3'b100, 120);

    run(3'b101, 150);
    #2 rst_n = 1'b0;
    #1;
    check("rst_level",   bus.button_level,   '0);
    check("rst_press",   bus.button_press,   '0);
    check("rst_release", bus.button_release, '0);
    check("rst_repeat",  bus.button_repeat,  '0);
    check("rst_step",    bus.button_step,    '0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    press_latency("rst_press_lat", 3'b101);
    run(3'b101, 100);
    run(3'b000, 40);

    random_phase(3000, 1'b0);
    random_phase(3000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
